// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming SECDED family: status codes, parity-width
// calculation and parity/data position mapping.
package hamming_pkg;

  localparam int unsigned MaxCwW = 64;

  typedef enum logic [1:0] {
    StatClean  = 2'd0,
    StatCorr   = 2'd1,
    StatDbl    = 2'd2,
    StatBadpos = 2'd3
  } status_e;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned par_bits(input int unsigned data_w);
    int unsigned r;
    r = 7;
    for (int i = 7; i >= 1; i--) begin
      if ((32'd1 << i) >= data_w + 32'(i) + 32'd1) r = 32'(i);
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Collects the non-power-of-two positions, lowest first, into the low data_w bits.
  function automatic logic [MaxCwW-1:0] extract_data(input logic [MaxCwW-1:0] code,
                                                     input int unsigned data_w);
    logic [MaxCwW-1:0] d;
    int unsigned k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos < MaxCwW; pos++) begin
      if (!is_pow2(pos) && (k < data_w)) begin
        d[k] = code[pos-1];
        k++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall-parity generator for an extended codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  localparam int unsigned PAR_W = par_bits(DATA_W),
  localparam int unsigned CW_W  = DATA_W + PAR_W + 1
) (
  input  logic [CW_W-1:0]  code,
  output logic [PAR_W-1:0] syndrome,
  output logic             op
);

  // The overall-parity bit at the MSB carries no Hamming position.
  always_comb begin
    syndrome = '0;
    for (int unsigned p = 1; p < CW_W; p++) begin
      for (int unsigned j = 0; j < PAR_W; j++) begin
        if (p[j]) syndrome[j] = syndrome[j] ^ code[p-1];
      end
    end
  end

  assign op = ^code;

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage streaming Hamming SECDED decoder with saturating error counters.
// Optional sticky uncorrectable-error flag enabled by HAMMING_STICKY_ERR_EN.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W = par_bits(DATA_W),
  localparam int unsigned CW_W  = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic [1:0]        out_status,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_dbl,
  output logic              err_sticky
);

  logic              s1_valid_q;
  logic [CW_W-1:0]   s1_code_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_op_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [PAR_W-1:0]  out_syn_q;
  status_e           out_status_q;

  logic [CNT_W-1:0]  cnt_corr_q;
  logic [CNT_W-1:0]  cnt_dbl_q;

  logic [PAR_W-1:0]  syn;
  logic              op;
  logic              s1_ready;
  logic              s2_ready;
  logic              out_fire;
  logic              out_uncorr;

  logic [CW_W-1:0]   corr_code;
  logic [MaxCwW-1:0] code_ext;
  logic [DATA_W-1:0] data_d;
  status_e           status_d;

  hamming_syndrome #(
    .DATA_W(DATA_W)
  ) u_syndrome (
    .code     (in_code),
    .syndrome (syn),
    .op       (op)
  );

  assign s2_ready   = !out_valid_q || out_ready;
  assign s1_ready   = !s1_valid_q || s2_ready;
  assign in_ready   = s1_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign out_uncorr = (out_status_q == StatDbl) || (out_status_q == StatBadpos);

  always_comb begin
    corr_code = s1_code_q;
    status_d  = StatClean;
    if (s1_op_q) begin
      if (s1_syn_q == '0) begin
        status_d = StatCorr;
      end else if (32'(s1_syn_q) < CW_W) begin
        status_d = StatCorr;
        for (int unsigned p = 1; p < CW_W; p++) begin
          if (32'(s1_syn_q) == p) corr_code[p-1] = ~corr_code[p-1];
        end
      end else begin
        status_d = StatBadpos;
      end
    end else if (s1_syn_q != '0) begin
      status_d = StatDbl;
    end
    code_ext            = '0;
    code_ext[CW_W-1:0]  = corr_code;
    data_d              = DATA_W'(extract_data(code_ext, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_op_q    <= 1'b0;
    end else if (s1_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_code_q <= in_code;
        s1_syn_q  <= syn;
        s1_op_q   <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_syn_q    <= '0;
      out_status_q <= StatClean;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= data_d;
        out_syn_q    <= s1_syn_q;
        out_status_q <= status_d;
      end
    end
  end

  // A clear wins over a same-cycle handshake; that word goes uncounted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr_q <= '0;
      cnt_dbl_q  <= '0;
    end else if (clr_cnt) begin
      cnt_corr_q <= '0;
      cnt_dbl_q  <= '0;
    end else if (out_fire) begin
      if ((out_status_q == StatCorr) && (cnt_corr_q != '1)) begin
        cnt_corr_q <= cnt_corr_q + CNT_W'(1);
      end
      if (out_uncorr && (cnt_dbl_q != '1)) begin
        cnt_dbl_q <= cnt_dbl_q + CNT_W'(1);
      end
    end
  end

`ifdef HAMMING_STICKY_ERR_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (clr_cnt) begin
      sticky_q <= 1'b0;
    end else if (out_fire && out_uncorr) begin
      sticky_q <= 1'b1;
    end
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = 1'b0;
`endif

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_syndrome = out_syn_q;
  assign out_status   = out_status_q;
  assign cnt_corr     = cnt_corr_q;
  assign cnt_dbl      = cnt_dbl_q;

endmodule
